instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// ============================================================================
// instr_fetch -- single-issue instruction fetch stage with IF/ID register
// ----------------------------------------------------------------------------
// Purpose
//   Holds the program counter, presents it to a combinational instruction
//   memory and captures the returned word into the IF/ID pipeline register.
//   Each cycle in RUN it either redirects (branch_taken), stalls (freeze) or
//   advances (PC += 4 and the fetched word moves into IF/ID). Redirects
//   always win over stalls, so a stalled pipe can still be flushed.
//
// Parameters
//   RESET_PC      byte address loaded into the PC on reset (bits [1:0] zero)
//
// Ports
//   clk           in   1   single clock, rising edge
//   rst_n         in   1   asynchronous active-low reset
//   freeze        in   1   hazard stall: hold PC, IF/ID and fetch_count
//   branch_taken  in   1   redirect request from a later stage
//   branch_addr   in  32   redirect target (byte address, low bits dropped)
//   imem_addr     out 32   instruction memory address, always the PC
//   imem_data     in  32   instruction word for imem_addr, same cycle
//   pc_out        out 32   IF/ID: address of fetched word + 4
//   instr_out     out 32   IF/ID: fetched instruction word
//   valid_out     out  1   IF/ID holds a real instruction
//   fetch_count   out 32   instructions accepted into IF/ID since reset
//
// Configuration
//   IF_HALT_DETECT_EN  when defined, fetching the self-loop word JMP -1
//                      (opcode 6'b101010, offset all ones) still delivers it
//                      into IF/ID and then parks the stage in HALT until a
//                      branch or reset. When undefined HALT is unreachable
//                      and JMP -1 is an ordinary instruction.
// ============================================================================
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] pc_out,
    output logic [31:0] instr_out,
    output logic        valid_out,
    output logic [31:0] fetch_count
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_pc_out;
    logic [31:0] r_instr;
    logic        r_valid;
    logic [31:0] r_count;

    // ------------------------------------------------------------------
    // Next-state wires
    // ------------------------------------------------------------------
    logic [1:0]  w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic [31:0] w_pc_out_nxt;
    logic [31:0] w_instr_nxt;
    logic        w_valid_nxt;
    logic [31:0] w_count_nxt;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_branch_tgt;
    logic        w_is_halt;

    // PC + 4 wraps naturally at 2^32.
    assign w_pc_plus4   = r_pc + 32'd4;

    // Targets are word aligned; the two low address bits are discarded.
    assign w_branch_tgt = branch_addr & 32'hFFFF_FFFC;

`ifdef IF_HALT_DETECT_EN
    // JMP -1: opcode 6'b101010 with an all-ones 26-bit offset jumps to itself.
    assign w_is_halt = (imem_data[31:26] == 6'b101010) && (&imem_data[25:0]);
`else
    assign w_is_halt = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every next value defaults to "hold" before the case, so no
        // path through the case can leave one unassigned and infer a latch.
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_pc_out_nxt = r_pc_out;
        w_instr_nxt  = r_instr;
        w_valid_nxt  = r_valid;
        w_count_nxt  = r_count;

        case (r_state)
            ST_IDLE: begin
                // One settling cycle after reset: PC parked, IF/ID empty.
                w_state_nxt  = ST_RUN;
                w_pc_nxt     = RESET_PC;
                w_pc_out_nxt = 32'd0;
                w_instr_nxt  = NOP_WORD;
                w_valid_nxt  = 1'b0;
            end

            ST_RUN: begin
                if (branch_taken) begin
                    // Redirect: the word at the old PC is wrong-path, flush it.
                    w_pc_nxt     = w_branch_tgt;
                    w_pc_out_nxt = 32'd0;
                    w_instr_nxt  = NOP_WORD;
                    w_valid_nxt  = 1'b0;
                end else if (!freeze) begin
                    // Advance: the only case where imem_data is captured.
                    w_pc_nxt     = w_pc_plus4;
                    w_pc_out_nxt = w_pc_plus4;
                    w_instr_nxt  = imem_data;
                    w_valid_nxt  = 1'b1;
                    w_count_nxt  = r_count + 32'd1;
                    if (w_is_halt) begin
                        w_state_nxt = ST_HALT;
                    end
                end
                // freeze alone: everything holds via the defaults.
            end

            ST_HALT: begin
                if (branch_taken) begin
                    w_state_nxt  = ST_RUN;
                    w_pc_nxt     = w_branch_tgt;
                end
                // Parked (or just redirected): IF/ID drains to a bubble.
                w_pc_out_nxt = 32'd0;
                w_instr_nxt  = NOP_WORD;
                w_valid_nxt  = 1'b0;
            end

            default: begin
                // Unreachable encoding: recover as if freshly reset.
                w_state_nxt  = ST_IDLE;
                w_pc_nxt     = RESET_PC;
                w_pc_out_nxt = 32'd0;
                w_instr_nxt  = NOP_WORD;
                w_valid_nxt  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_pc     <= RESET_PC;
            r_pc_out <= 32'd0;
            r_instr  <= NOP_WORD;
            r_valid  <= 1'b0;
            r_count  <= 32'd0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_pc_out <= w_pc_out_nxt;
            r_instr  <= w_instr_nxt;
            r_valid  <= w_valid_nxt;
            r_count  <= w_count_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign imem_addr   = r_pc;
    assign pc_out      = r_pc_out;
    assign instr_out   = r_instr;
    assign valid_out   = r_valid;
    assign fetch_count = r_count;

endmodule
